ct_spsram_512x22_arb: RTL
=========================

CT_SPSRAM_512X22_ARB -- requirements
Module: ct_spsram_512x22_arb

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 9, SRAM word address width; DATA_WIDTH, default 22, SRAM word width; HALF_WIDTH, default 11, width of one write-enable lane.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports as follows (name, direction, width, meaning):
REQ-003 forever_cpuclk  in  1  sole clock; all state updates on its rising edge.
REQ-004 cpurst_b  in  1  asynchronous active-low reset.
REQ-005 reqN_vld  in  1  (N=0,1) requester N presents a command.
REQ-006 reqN_wr  in  1  1=write, 0=read.
REQ-007 reqN_addr  in  ADDR_WIDTH  word address.
REQ-008 reqN_wdata  in  DATA_WIDTH  write data.
REQ-009 reqN_be  in  2  active-high lane enables; bit0=[10:0], bit1=[21:11].
REQ-010 reqN_rdy  out  1  command accepted this cycle (vld&rdy = grant).
REQ-011 rspN_vld  out  1  read data for requester N is valid on rsp_rdata.
REQ-012 rsp_rdata  out  DATA_WIDTH  shared read-return data.
REQ-013 sram_a/sram_cen/sram_gwen/sram_wen/sram_d  out  ADDR_WIDTH/1/1/DATA_WIDTH/DATA_WIDTH  SRAM command; CEN, GWEN and WEN are active low.
REQ-014 sram_q  in  DATA_WIDTH  SRAM read data, valid one cycle after a read command.
REQ-015 init_done  out  1  array initialised; arbitration enabled.

Function
REQ-016 SHALL grant at most one request per cycle; grant is combinational in the same cycle as vld.
REQ-017 SHALL use round-robin with a 1-bit priority pointer prio: if both are valid, grant req[prio]; if only one is valid, grant it.
REQ-018 After any grant to requester i, prio SHALL become ~i.
REQ-019 On a grant, SHALL drive sram_cen=0, sram_a=addr and sram_d=wdata; gwen=~wr; sram_wen={{11{~be[1]}},{11{~be[0]}}} for writes and all-ones for reads.
REQ-020 With no grant, sram_cen=1, sram_gwen=1 and sram_wen all-ones; sram_a and sram_d SHALL be don't-care.
REQ-021 A write with be=2'b00 SHALL still be granted and consume the slot, but modify nothing.
REQ-022 A read granted in cycle N SHALL assert rspN_vld for exactly cycle N+1, with rsp_rdata=sram_q; latency is 1 cycle.
REQ-023 Responses have no backpressure; requesters SHALL always accept them.
REQ-024 Throughput SHALL be one command per cycle; back-to-back reads give back-to-back responses.
REQ-025 A write granted in cycle N followed by a read of the same address in N+1 SHALL return the new data.
REQ-026 States: INIT, RUN.
REQ-027 In INIT, reqN_rdy=0 and a 9-bit counter drives writes of all-zero data to addresses 0..511, one per cycle.
REQ-028 After address 511 is written, the block SHALL go to RUN and set init_done=1 in the next cycle.
REQ-029 The counter SHALL NOT wrap; RUN is terminal until reset.

Reset
REQ-030 While cpurst_b=0: prio=0, rsp0_vld=rsp1_vld=0, state=INIT, counter=0, init_done=0, sram_cen=1.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL abort immediately; a read in flight SHALL produce no response.
REQ-032 After reset release, sweep restarts from address 0.

Configuration
REQ-033 Macro CT_SPSRAM_ARB_INIT_EN SHALL control the INIT sweep.
REQ-034 When defined: INIT sweep per REQ-027..029.
REQ-035 When undefined: no INIT state and no counter; reset enters RUN, init_done is 1 from the first cycle after reset release, and array contents are undefined until written.

Structure
REQ-036 A shared package ct_spsram_arb_pkg SHALL hold the state enum (INIT, RUN), the ADDR_WIDTH/DATA_WIDTH/HALF_WIDTH defaults and the DEPTH=512 constant.
REQ-037 One sub-module ct_spsram_rr_arb2 (2-way round-robin grant plus prio register) SHALL be instantiated; datapath muxing stays in the top.

Verification
REQ-038 Init (macro on): release reset -> 512 consecutive writes, addr 0..511, data 0, reqN_rdy=0 throughout; init_done=1 in cycle 513.
REQ-039 Contention: both valid every cycle for 4 cycles from reset prio=0 -> grants 0,1,0,1.
REQ-040 Read latency: req1 writes 0x2AAAAA to addr 0x1FF with be=11, then reads it -> rsp1_vld exactly one cycle after the read grant, rsp_rdata=0x2AAAAA, rsp0_vld=0.
REQ-041 Lane write: write 0x3FFFFF with be=11, then 0x000000 with be=01 to addr 5, then read -> 0x3FF800.
REQ-042 Reset mid-sweep: assert cpurst_b=0 at counter=100 -> sram_cen=1 immediately; after release, sweep restarts at addr 0.
REQ-043 Macro off: release reset -> init_done=1 and req0 read granted in the first cycle.

Source files
------------

// File: rtl/ct_spsram_arb_pkg.sv
// Shared constants and state type for the 512x22 single-port SRAM arbiter.
package ct_spsram_arb_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 9;
  localparam int unsigned DATA_WIDTH_DEF = 22;
  localparam int unsigned HALF_WIDTH_DEF = 11;
  localparam int unsigned DEPTH          = 512;

  typedef enum logic {
    StInit,
    StRun
  } state_e;

endpackage

// File: rtl/ct_spsram_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant and a 1-bit priority pointer.
module ct_spsram_rr_arb2 (
  input  logic       forever_cpuclk,
  input  logic       cpurst_b,
  input  logic       en,
  input  logic [1:0] vld,
  output logic [1:0] gnt
);

  logic prio_q, prio_d;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    if (en) begin
      if (vld == 2'b11) begin
        gnt = prio_q ? 2'b10 : 2'b01;
      end else begin
        gnt = vld;
      end
    end
    // The requester just served drops to lowest priority.
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

endmodule

// File: rtl/ct_spsram_512x22_arb.sv
// Two-requester front end for a 512x22 single-port SRAM with optional zero-fill sweep.
// Define CT_SPSRAM_ARB_INIT_EN to clear the array after reset before arbitration starts.
module ct_spsram_512x22_arb
  import ct_spsram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned HALF_WIDTH = HALF_WIDTH_DEF
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req0_vld,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [1:0]            req0_be,
  output logic                  req0_rdy,
  input  logic                  req1_vld,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [1:0]            req1_be,
  output logic                  req1_rdy,
  output logic                  rsp0_vld,
  output logic                  rsp1_vld,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output logic                  init_done
);

  logic                  live_q;
  logic                  run;
  logic                  sweep;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic [1:0]            gnt;
  logic [1:0]            rsp_vld_q;
  logic                  sel;
  logic                  wr_sel;
  logic [1:0]            be_sel;

  // Keeps the SRAM idle while reset is asserted, even though the FSM sits in its sweep state.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

`ifdef CT_SPSRAM_ARB_INIT_EN
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sweep   = live_q && (state_q == StInit);
    if (sweep) begin
      if (cnt_q == LastAddr) begin
        state_d = StRun;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign sweep_addr = cnt_q;
  assign run        = (state_q == StRun);
`else
  assign sweep      = 1'b0;
  assign sweep_addr = '0;
  assign run        = live_q;
`endif

  assign init_done = run;

  ct_spsram_rr_arb2 u_arb (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .en             (run),
    .vld            ({req1_vld, req0_vld}),
    .gnt            (gnt)
  );

  assign req0_rdy = gnt[0];
  assign req1_rdy = gnt[1];
  assign sel      = gnt[1];
  assign wr_sel   = sel ? req1_wr : req0_wr;
  assign be_sel   = sel ? req1_be : req0_be;

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = sel ? req1_addr : req0_addr;
    sram_d    = sel ? req1_wdata : req0_wdata;
    if (sweep) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = sweep_addr;
      sram_d    = '0;
    end else if (|gnt) begin
      sram_cen  = 1'b0;
      sram_gwen = ~wr_sel;
      if (wr_sel) begin
        sram_wen = {{HALF_WIDTH{~be_sel[1]}}, {HALF_WIDTH{~be_sel[0]}}};
      end
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rsp_vld_q <= 2'b00;
    end else begin
      rsp_vld_q <= gnt & {~req1_wr, ~req0_wr};
    end
  end

  assign rsp0_vld  = rsp_vld_q[0];
  assign rsp1_vld  = rsp_vld_q[1];
  assign rsp_rdata = sram_q;

endmodule
